// File: rtl/sram_xfer_seq_if.sv
// Host command/stream and SRAM/address-counter signals of the AVR-phase transfer sequencer.
// The sequencer side uses the master modport; the host/SRAM side uses slave.
interface sram_xfer_seq_if #(
    parameter int LEN_W = 21
);
    logic             START;
    logic             ABORT;
    logic             DIR;
    logic [1:0]       BANK;
    logic [LEN_W-1:0] LEN;
    logic             BUSY;
    logic             DONE;
    logic             MODE;
    logic [1:0]       AVR_BANK;
    logic             ADDR_RESET;
    logic             ADDR_EN;
    logic             NEXTADDR;
    logic             SRAM_OE_N;
    logic             SRAM_WE_N;
    logic [7:0]       SRAM_DIN;
    logic [7:0]       SRAM_DOUT;
    logic [7:0]       RD_DATA;
    logic             RD_VALID;
    logic             RD_READY;
    logic [7:0]       WR_DATA;
    logic             WR_VALID;
    logic             WR_READY;

    modport master (
        input  START, ABORT, DIR, BANK, LEN, SRAM_DIN, RD_READY, WR_DATA, WR_VALID,
        output BUSY, DONE, MODE, AVR_BANK, ADDR_RESET, ADDR_EN, NEXTADDR,
               SRAM_OE_N, SRAM_WE_N, SRAM_DOUT, RD_DATA, RD_VALID, WR_READY
    );

    modport slave (
        output START, ABORT, DIR, BANK, LEN, SRAM_DIN, RD_READY, WR_DATA, WR_VALID,
        input  BUSY, DONE, MODE, AVR_BANK, ADDR_RESET, ADDR_EN, NEXTADDR,
               SRAM_OE_N, SRAM_WE_N, SRAM_DOUT, RD_DATA, RD_VALID, WR_READY
    );
endinterface

// File: rtl/sram_xfer_seq.sv
// AVR bus-phase sequencer: resets/steps the external address counter and strobes the SRAM
// to move LEN bytes between the host byte streams and SRAM.
module sram_xfer_seq #(
    parameter int LEN_W    = 21,
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2,
    parameter int SYNC_DLY = 2
) (
    input logic             CLK,
    input logic             RST_N,
    sram_xfer_seq_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ARST_HI, S_ARST_LO, S_RD_ACC, S_RD_HAND,
        S_WR_WAIT, S_WR_ACC, S_STEP_HI, S_STEP_LO, S_FIN
    } state_t;

    localparam int CNT_W = 8;
    localparam int HOLD  = SYNC_DLY + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [1:0]       bank_q, bank_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [7:0]       dout_q, dout_d;
    logic             last_byte;
    logic [LEN_W-1:0] rem_dec;

    logic busy_q, done_q, nextaddr_q, addr_reset_q, addr_en_q;
    logic oe_n_q, we_n_q, rd_valid_q, wr_ready_q;

    assign last_byte = (rem_q <= LEN_W'(1));
    assign rem_dec   = (rem_q == '0) ? '0 : rem_q - 1'b1;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        rem_d     = rem_q;
        dir_d     = dir_q;
        bank_d    = bank_q;
        rd_data_d = rd_data_q;
        dout_d    = dout_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    if (bus.LEN != '0) begin
                        state_d = S_ARST_HI;
                        dir_d   = bus.DIR;
                        bank_d  = bus.BANK;
                        rem_d   = bus.LEN;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_ARST_HI: state_d = S_ARST_LO;
            S_ARST_LO, S_STEP_LO: begin
                if (cnt_q == CNT_W'(HOLD - 1)) state_d = dir_q ? S_WR_WAIT : S_RD_ACC;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            S_RD_ACC: begin
                if (cnt_q == CNT_W'(RD_WAIT - 1)) begin
                    rd_data_d = bus.SRAM_DIN;
                    state_d   = S_RD_HAND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_HAND: begin
                if (bus.RD_READY) begin
                    rem_d   = rem_dec;
                    state_d = last_byte ? S_FIN : S_STEP_HI;
                end
            end
            S_WR_WAIT: begin
                if (bus.WR_VALID) begin
                    dout_d  = bus.WR_DATA;
                    state_d = S_WR_ACC;
                end
            end
            S_WR_ACC: begin
                if (cnt_q == CNT_W'(WR_PULSE - 1)) begin
                    rem_d   = rem_dec;
                    state_d = last_byte ? S_FIN : S_STEP_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STEP_HI: state_d = S_STEP_LO;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Abort outranks every handshake; data registers keep their last values.
        if (bus.ABORT && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            rem_d     = '0;
            rd_data_d = rd_data_q;
            dout_d    = dout_q;
        end
    end

    // NOTE: sequential state uses <= so every register updates from the same pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            dir_q        <= 1'b0;
            bank_q       <= 2'd0;
            rd_data_q    <= 8'd0;
            dout_q       <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            nextaddr_q   <= 1'b0;
            addr_reset_q <= 1'b1;
            addr_en_q    <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            rd_valid_q   <= 1'b0;
            wr_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            dir_q        <= dir_d;
            bank_q       <= bank_d;
            rd_data_q    <= rd_data_d;
            dout_q       <= dout_d;
            // Strobes are decoded from the next state and registered so they never glitch.
            busy_q       <= !(state_d inside {S_IDLE, S_FIN});
            done_q       <= (state_d == S_FIN);
            nextaddr_q   <= (state_d inside {S_ARST_HI, S_STEP_HI});
            addr_reset_q <= !(state_d inside {S_ARST_HI, S_ARST_LO});
            addr_en_q    <= !(state_d inside {S_STEP_HI, S_STEP_LO});
            oe_n_q       <= (state_d != S_RD_ACC);
            we_n_q       <= (state_d != S_WR_ACC);
            rd_valid_q   <= (state_d == S_RD_HAND);
            wr_ready_q   <= (state_d == S_WR_WAIT);
        end
    end

    assign bus.BUSY       = busy_q;
    assign bus.MODE       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.AVR_BANK   = bank_q;
    assign bus.ADDR_RESET = addr_reset_q;
    assign bus.ADDR_EN    = addr_en_q;
    assign bus.NEXTADDR   = nextaddr_q;
    assign bus.SRAM_OE_N  = oe_n_q;
    assign bus.SRAM_WE_N  = we_n_q;
    assign bus.SRAM_DOUT  = dout_q;
    assign bus.RD_DATA    = rd_data_q;
    assign bus.RD_VALID   = rd_valid_q;
    assign bus.WR_READY   = wr_ready_q;
endmodule
